// File: rtl/shift_register_sequencer.sv
// Word-to-serial command sequencer for the downstream priority shift register.
// Ports: clockPulse/Reset; wordData/wordValid/wordReady in; msbFirst/fillBit
// per-frame controls; ParallelLoad/ShiftLeft/ShiftRight/ShiftInput/Data to
// the register; bitStrobe/frameActive/frameDone status.
module shift_register_sequencer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic             clockPulse,
  input  logic             Reset,
  input  logic [WIDTH-1:0] wordData,
  input  logic             wordValid,
  output logic             wordReady,
  input  logic             msbFirst,
  input  logic             fillBit,
  output logic             ParallelLoad,
  output logic             ShiftLeft,
  output logic             ShiftRight,
  output logic             ShiftInput,
  output logic [WIDTH-1:0] Data,
  output logic             bitStrobe,
  output logic             frameActive,
  output logic             frameDone
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LastGap =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [WIDTH-1:0] fifoMem [2];
  logic             wrPtr, rdPtr;
  logic [1:0]       count, countNext;
  logic             dir, fill;
  logic             push, pop, notEmpty;

  logic             plN, slN, srN, siN, faN, fdN;
  logic [WIDTH-1:0] dataN;

  assign notEmpty = (count != 2'd0);
  assign push     = wordValid && wordReady;

  always_comb begin
    countNext = count;
    unique case ({push, pop})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase
  end

  // Next state; a pop is only ever issued on the way into LOAD.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (notEmpty) begin
          stateNext = LOAD;
          pop       = 1'b1;
        end
      end
      LOAD: begin
        stateNext = SHIFT;
        cntNext   = '0;
      end
      SHIFT: begin
        if (cnt == LastBit) begin
          cntNext = '0;
          if (GAP_CYCLES > 0) begin
            stateNext = GAP;
          end else if (notEmpty) begin
            stateNext = LOAD;
            pop       = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == LastGap) begin
          cntNext = '0;
          if (notEmpty) begin
            stateNext = LOAD;
            pop       = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are registered alongside it.
  // dir/fill are already latched by the time SHIFT is entered.
  always_comb begin
    plN   = (stateNext == LOAD);
    slN   = (stateNext == SHIFT) && dir;
    srN   = (stateNext == SHIFT) && !dir;
    siN   = (stateNext == SHIFT) && fill;
    dataN = plN ? fifoMem[rdPtr] : '0;
    faN   = plN || (stateNext == SHIFT);
    fdN   = (state == SHIFT) && (cnt == LastBit);
  end

  always_ff @(posedge clockPulse) begin
    if (push) begin
      fifoMem[wrPtr] <= wordData;
    end
  end

  always_ff @(posedge clockPulse) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      count        <= 2'd0;
      wrPtr        <= 1'b0;
      rdPtr        <= 1'b0;
      dir          <= 1'b0;
      fill         <= 1'b0;
      wordReady    <= 1'b0;
      ParallelLoad <= 1'b0;
      ShiftLeft    <= 1'b0;
      ShiftRight   <= 1'b0;
      ShiftInput   <= 1'b0;
      Data         <= '0;
      bitStrobe    <= 1'b0;
      frameActive  <= 1'b0;
      frameDone    <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      count     <= countNext;
      wordReady <= (countNext < 2'd2);
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
        dir   <= msbFirst;
        fill  <= fillBit;
      end
      ParallelLoad <= plN;
      ShiftLeft    <= slN;
      ShiftRight   <= srN;
      ShiftInput   <= siN;
      Data         <= dataN;
      // The register shifts on the edge that samples the command, so its
      // ShiftOutput holds the new bit during the following cycle.
      bitStrobe    <= ShiftLeft || ShiftRight;
      frameActive  <= faN;
      frameDone    <= fdN;
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench: scoreboard of pushed words against a shift register model.
// Ports: drives every sequencer input, observes every output.
module tb_shift_register_sequencer;

  localparam int W   = 4;
  localparam int GAP = 0;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] wordData = '0;
  logic         wordValid = 1'b0;
  logic         msbFirst = 1'b0;
  logic         fillBit = 1'b0;
  logic         wordReady;
  logic         ParallelLoad, ShiftLeft, ShiftRight, ShiftInput;
  logic [W-1:0] Data;
  logic         bitStrobe, frameActive, frameDone;

  always #5 clk = ~clk;

  shift_register_sequencer #(
    .WIDTH(W),
    .GAP_CYCLES(GAP),
    .CNT_W(3)
  ) dut (
    .clockPulse(clk),
    .Reset(Reset),
    .wordData(wordData),
    .wordValid(wordValid),
    .wordReady(wordReady),
    .msbFirst(msbFirst),
    .fillBit(fillBit),
    .ParallelLoad(ParallelLoad),
    .ShiftLeft(ShiftLeft),
    .ShiftRight(ShiftRight),
    .ShiftInput(ShiftInput),
    .Data(Data),
    .bitStrobe(bitStrobe),
    .frameActive(frameActive),
    .frameDone(frameDone)
  );

  typedef struct packed {
    logic [W-1:0] w;
    logic         d;
    logic         f;
  } ent_t;

  int nPass = 0;
  int nTotal = 0;

  ent_t   pushQ[$];
  logic   bitQ[$];
  int     plCyc[$];
  logic   monEn = 1'b0;
  logic   curDir = 1'b0;
  logic   curFill = 1'b0;
  logic [W-1:0] srQ = '0;
  logic   srOut = 1'b0;
  int     strobeCnt = 0;
  int     doneCnt = 0;
  int     cyc = 0;
  logic   stallSeen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nTotal = nTotal + 1;
    assert (obs === exp) nPass = nPass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    ent_t e;
    ent_t n;
    chk("onehot",
        32'($countones({ParallelLoad, ShiftLeft, ShiftRight}) <= 1), 1);
    chk("frameActive", frameActive,
        ParallelLoad | ShiftLeft | ShiftRight);
    if (bitStrobe) begin
      chk("bitAvail", 32'(bitQ.size() > 0), 1);
      if (bitQ.size() > 0) chk("serialBit", srOut, bitQ.pop_front());
      strobeCnt++;
    end
    if (frameDone) begin
      chk("doneWithStrobe", bitStrobe, 1);
      chk("strobesPerFrame", strobeCnt, W);
      strobeCnt = 0;
      doneCnt++;
    end
    if (ParallelLoad) begin
      plCyc.push_back(cyc);
      chk("loadAvail", 32'(pushQ.size() > 0), 1);
      if (pushQ.size() > 0) begin
        e = pushQ.pop_front();
        chk("loadData", Data, e.w);
        curDir = e.d;
        curFill = e.f;
        for (int i = 0; i < W; i++)
          bitQ.push_back(e.d ? e.w[W-1-i] : e.w[i]);
      end
    end
    if (ShiftLeft | ShiftRight) begin
      chk("shiftDir", ShiftLeft, curDir);
      chk("shiftFill", ShiftInput, curFill);
      chk("shiftData", Data, 0);
    end
    if (ParallelLoad) begin
      srQ = Data;
    end else if (ShiftLeft) begin
      srOut = srQ[W-1];
      srQ = {srQ[W-2:0], ShiftInput};
    end else if (ShiftRight) begin
      srOut = srQ[0];
      srQ = {ShiftInput, srQ[W-1:1]};
    end
    if (wordValid && !Reset) begin
      if (wordReady) begin
        n.w = wordData;
        n.d = msbFirst;
        n.f = fillBit;
        pushQ.push_back(n);
      end else begin
        stallSeen = 1'b1;
      end
    end
    if (Reset) begin
      pushQ.delete();
      bitQ.delete();
      strobeCnt = 0;
    end
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (monEn) monitor();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  task automatic pushWord(input logic [W-1:0] w, input logic d,
                          input logic f);
    int n = 0;
    wordData = w;
    msbFirst = d;
    fillBit = f;
    wordValid = 1'b1;
    while (!wordReady && n < 50) begin
      tick();
      n++;
    end
    chk("pushTimeout", 32'(n < 50), 1);
    tick();
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCnt < target && n < 200) begin
      tick();
      n++;
    end
    chk("frameDoneCount", doneCnt, target);
    chk("bitQEmpty", bitQ.size(), 0);
  endtask

  initial begin
    Reset = 1'b1;
    wordValid = 1'b1;
    wordData = 4'hF;
    repeat (3) begin
      tick();
      chk("rstCmds", {ParallelLoad, ShiftLeft, ShiftRight, ShiftInput}, 0);
      chk("rstData", Data, 0);
      chk("rstFlags", {bitStrobe, frameActive, frameDone, wordReady}, 0);
    end
    monEn = 1'b1;
    Reset = 1'b0;
    wordValid = 1'b0;
    tick();
    chk("readyAfterRst", wordReady, 1);
    tick();
    chk("noPushInRst", ParallelLoad, 0);

    pushWord(4'b1010, 1'b1, 1'b0);
    wordValid = 1'b0;
    tick();
    chk("latLoad", ParallelLoad, 1);
    chk("latData", Data, 4'b1010);
    tick();
    chk("firstShiftL", ShiftLeft, 1);
    tick();
    chk("firstStrobe", bitStrobe, 1);
    waitDone(1);

    pushWord(4'b1100, 1'b0, 1'b1);
    wordValid = 1'b0;
    tick();
    tick();
    chk("shiftR", ShiftRight, 1);
    chk("fillOne", ShiftInput, 1);
    repeat (3) begin
      msbFirst = ~msbFirst;
      tick();
      chk("holdDirR", ShiftRight, 1);
    end
    msbFirst = 1'b0;
    waitDone(2);

    plCyc.delete();
    stallSeen = 1'b0;
    pushWord(4'h9, 1'b1, 1'b1);
    pushWord(4'h6, 1'b1, 1'b1);
    pushWord(4'hC, 1'b1, 1'b1);
    pushWord(4'h5, 1'b1, 1'b1);
    wordValid = 1'b0;
    waitDone(6);
    chk("stallSeen", stallSeen, 1);
    chk("b2bLoads", plCyc.size(), 4);
    for (int i = 1; i < plCyc.size(); i++)
      chk("framePeriod", plCyc[i] - plCyc[i-1], 1 + W + GAP);

    pushWord(4'b0110, 1'b1, 1'b0);
    pushWord(4'b1001, 1'b1, 1'b0);
    wordValid = 1'b0;
    tick();
    tick();
    chk("rstMidShift", ShiftLeft, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abortCmds", {ParallelLoad, ShiftLeft, ShiftRight, ShiftInput}, 0);
    chk("abortData", Data, 0);
    chk("abortFlags", {bitStrobe, frameActive, frameDone, wordReady}, 0);
    tick();
    chk("readyAfterAbort", wordReady, 1);
    repeat (4) begin
      tick();
      chk("fifoFlushed", ParallelLoad, 0);
    end
    chk("noDoneAfterAbort", doneCnt, 6);
    pushWord(4'b1011, 1'b0, 1'b1);
    wordValid = 1'b0;
    waitDone(7);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
